alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/add/shift ops and iterative multiply/divide.
// One request in flight; the result is held in DONE until out_ready is seen.
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             of,
  output logic             zf,
  output logic             dz
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = SW + 1;

  localparam logic [3:0] OpAnd  = 4'h1;
  localparam logic [3:0] OpOr   = 4'h2;
  localparam logic [3:0] OpXor  = 4'h3;
  localparam logic [3:0] OpAdds = 4'h4;
  localparam logic [3:0] OpAddu = 4'h5;
  localparam logic [3:0] OpSubs = 4'h6;
  localparam logic [3:0] OpSubu = 4'h7;
  localparam logic [3:0] OpShrl = 4'h8;
  localparam logic [3:0] OpShll = 4'h9;
  localparam logic [3:0] OpShra = 4'hA;
  localparam logic [3:0] OpMul  = 4'hB;
  localparam logic [3:0] OpDivu = 4'hC;
  localparam logic [3:0] OpRemu = 4'hD;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  // a_q: multiplicand (MUL) or dividend/quotient shift register (DIV/REM)
  logic [WIDTH-1:0] a_q, a_d;
  // b_q: multiplier shifted right (MUL) or divisor (DIV/REM)
  logic [WIDTH-1:0] b_q, b_d;
  // acc_q: partial product (MUL) or partial remainder (DIV/REM)
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             of_q, of_d, zf_q, zf_d, dz_q, dz_d;

  logic [SW-1:0]    sh;
  logic [WIDTH-1:0] sum, diff, res;
  logic             res_of, is_div, div_zero, is_iter;
  logic [WIDTH-1:0] mul_acc_nx, rem_nx, quo_nx, iter_res;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;

  // Single-cycle datapath, evaluated on the request inputs at acceptance.
  always_comb begin
    sh       = in_1[SW-1:0];
    sum      = in_0 + in_1;
    diff     = in_0 - in_1;
    res      = in_0;
    res_of   = 1'b0;
    is_div   = (op == OpDivu) || (op == OpRemu);
    div_zero = is_div && (in_1 == '0);
    is_iter  = (op == OpMul) || (is_div && !div_zero);
    case (op)
      OpAnd:  res = in_0 & in_1;
      OpOr:   res = in_0 | in_1;
      OpXor:  res = in_0 ^ in_1;
      OpAdds: begin
        res    = sum;
        res_of = (in_0[WIDTH-1] == in_1[WIDTH-1]) && (sum[WIDTH-1] != in_0[WIDTH-1]);
      end
      OpAddu: res = sum;
      OpSubs: begin
        res    = diff;
        res_of = (in_0[WIDTH-1] != in_1[WIDTH-1]) && (diff[WIDTH-1] != in_0[WIDTH-1]);
      end
      OpSubu: res = diff;
      OpShrl: res = in_0 >> sh;
      OpShll: res = in_0 << sh;
      OpShra: res = $signed(in_0) >>> sh;
      OpDivu: res = div_zero ? '1 : in_0;
      default: res = in_0;
    endcase
  end

  // One iteration step of shift-add multiply and restoring divide.
  always_comb begin
    mul_acc_nx = acc_q + (b_q[0] ? a_q : '0);
    rem_sh     = {acc_q, a_q[WIDTH-1]};
    div_ge     = rem_sh >= {1'b0, b_q};
    rem_nx     = div_ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
    quo_nx     = {a_q[WIDTH-2:0], div_ge};
    if (op_q == OpMul) begin
      iter_res = mul_acc_nx;
    end else if (op_q == OpDivu) begin
      iter_res = quo_nx;
    end else begin
      iter_res = rem_nx;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    of_d      = of_q;
    zf_d      = zf_q;
    dz_d      = dz_q;
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d = op;
          if (is_iter) begin
            state_d = StBusy;
            a_d     = in_0;
            b_d     = in_1;
            acc_d   = '0;
            cnt_d   = CW'(WIDTH);
          end else begin
            state_d = StDone;
            out_d   = res;
            of_d    = res_of;
            zf_d    = (res == '0);
            dz_d    = div_zero;
          end
        end
      end
      StBusy: begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        if (op_q == OpMul) begin
          acc_d = mul_acc_nx;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end else begin
          acc_d = rem_nx;
          a_d   = quo_nx;
        end
        if (cnt_q <= CW'(1)) begin
          state_d = StDone;
          out_d   = iter_res;
          of_d    = 1'b0;
          zf_d    = (iter_res == '0);
          dz_d    = 1'b0;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      of_q    <= 1'b0;
      zf_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      of_q    <= of_d;
      zf_q    <= zf_d;
      dz_q    <= dz_d;
    end
  end

  assign out = out_q;
  assign of  = of_q;
  assign zf  = zf_q;
  assign dz  = dz_q;

endmodule
